multdiv_seq: RTL and testbench
==============================

Name: multdiv_seq

Overview:
- Multi-cycle signed 32-bit multiply/divide unit in the processor execute stage, beside the single-cycle ALU (bitwise AND/OR, add, shift).
- Accepts operands from the register-read latch on a one-cycle start pulse.
- Iterates with shift-add multiply or restoring division.
- Returns a registered 32-bit result plus an exception flag to the writeback/stall logic on a one-cycle ready pulse.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.
- CNT_W, 6, iteration counter width; must hold WIDTH+1.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- data_operandA  input  32  multiplicand / dividend, two's complement.
- data_operandB  input  32  multiplier / divisor, two's complement.
- ctrl_MULT  input  1  start-multiply pulse, sampled each rising edge.
- ctrl_DIV  input  1  start-divide pulse, sampled each rising edge.
- data_result  output  32  product low word or quotient.
- data_exception  output  1  overflow or divide-by-zero, valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle result-valid pulse.
- busy  output  1  high while an operation is in flight; used as the pipeline stall.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; counter and internal registers cleared. Reset mid-operation abandons the operation with no ready pulse.
- States: IDLE, MUL_IT, DIV_IT, FIX, DONE.
- Start cycle T (ctrl sampled high):
  - Latch operands, sign bits, magnitudes |A| and |B|.
  - Clear the accumulator/remainder; counter=0.
  - Go to MUL_IT or DIV_IT; busy=1 from T+1.
- Start priority: ctrl_MULT and ctrl_DIV high together -> multiply wins.
- Restart: a start pulse in any state (including mid-iteration or DONE) aborts the current operation and restarts from T. The aborted operation produces no ready pulse.
- MUL_IT:
  - Unsigned shift-add on magnitudes, one multiplier bit per cycle, into a 64-bit product register.
  - Exactly 32 cycles (T+1..T+32), then FIX.
- DIV_IT:
  - Restoring division of |A| by |B|: shift the remainder left, trial-subtract, set one quotient bit per cycle.
  - 32 cycles (T+1..T+32), then FIX.
  - Divide by zero (B==0 at T): skip iteration, go straight to FIX at T+1.
- FIX (one cycle):
  - Negate the result if signA^signB; quotient truncates toward zero; remainder is discarded.
  - Register data_result and data_exception, then go to DONE.
- Exceptions:
  - Multiply: exception=1 when the signed 64-bit product is not representable in 32 bits (upper 33 bits not all equal); data_result is still the low 32 bits.
  - Divide by zero: data_result=0, exception=1.
  - 0x80000000 / -1: data_result=0x80000000, exception=1.
- DONE:
  - data_resultRDY=1 for exactly this cycle; busy=0; return to IDLE next cycle.
  - data_result and data_exception hold their values until the next FIX or reset.
- Latency:
  - Normal: data_resultRDY high in cycle T+34.
  - Divide by zero: high in cycle T+2.
- Operand inputs are don't-care after T.

Optional Feature:
- Macro: MULTDIV_EARLY_TERM_EN.
- Defined: MUL_IT exits to FIX once the remaining unshifted multiplier magnitude is zero.
  - Iterations k = max(1, bit length of |B|); ready in cycle T+k+2.
  - |B|=0 -> k=1, ready at T+3.
  - Division latency is unchanged.
- Undefined: multiply always takes 32 iterations (ready at T+34); no zero-detect logic is built.

Test Plan:
- ctrl_MULT, A=7, B=-6 -> data_result=0xFFFFFFD6 (-42), exception=0, RDY only in T+34, busy high T+1..T+33.
- ctrl_MULT, A=0x40000000, B=4 -> data_result=0x00000000, exception=1; A=-1, B=-1 -> 1, exception=0.
- ctrl_DIV, A=-7, B=2 -> data_result=0xFFFFFFFD (-3), exception=0 at T+34; A=0x80000000, B=-1 -> 0x80000000, exception=1.
- ctrl_DIV, A=5, B=0 -> data_result=0, exception=1, RDY in T+2, busy high only T+1.
- Start MULT 3*3, then pulse ctrl_DIV with A=100, B=7 at T+10 -> no RDY for the multiply; quotient 14 with RDY at T+10+34. With MULTDIV_EARLY_TERM_EN, 3*3 alone -> 9, RDY at T+4.
- resetn low at T+15 of a multiply -> all outputs 0 immediately, no RDY; ctrl_MULT after release with A=2, B=3 -> 6 at the new T+34.

Source files
------------

// File: rtl/multdiv_seq_if.sv
// Operand/result bundle between the register-read latch, the multiply/divide
// unit and the writeback/stall logic.
interface multdiv_seq_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_seq.sv
// Multi-cycle signed multiply (shift-add) / divide (restoring) unit.
// Optional macro MULTDIV_EARLY_TERM_EN: multiply stops once the remaining multiplier bits are zero.
module multdiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clock,
    input  logic         resetn,
    multdiv_seq_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_IT,
        S_DIV_IT,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_is_div;
    logic               r_div0;
    logic [2*WIDTH-1:0] r_acc;    // product, or {remainder, dividend/quotient} while dividing
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_opb;    // multiplier shifting right, or divisor magnitude
    logic [WIDTH-1:0]   r_result;
    logic               r_exc;
    logic               r_rdy;
    logic               r_busy;

    logic               w_start;
    logic               w_start_mul;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_b_zero;
    logic [2*WIDTH-1:0] w_mul_next;
    logic               w_mul_last;
    logic [2*WIDTH-1:0] w_div_shift;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;
    logic [WIDTH-1:0]   w_quo;
    logic               w_div_exc;

    // Multiply takes priority when both start strobes arrive together.
    assign w_start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign w_start_mul = bus.ctrl_MULT;
    assign w_a_neg     = bus.data_operandA[WIDTH-1];
    assign w_b_neg     = bus.data_operandB[WIDTH-1];
    assign w_a_mag     = w_a_neg ? -bus.data_operandA : bus.data_operandA;
    assign w_b_mag     = w_b_neg ? -bus.data_operandB : bus.data_operandB;
    assign w_b_zero    = (bus.data_operandB == '0);

    assign w_mul_next  = r_opb[0] ? (r_acc + r_mcand) : r_acc;

`ifdef MULTDIV_EARLY_TERM_EN
    assign w_mul_last  = (r_cnt == LAST_IT) || (r_opb[WIDTH-1:1] == '0);
`else
    assign w_mul_last  = (r_cnt == LAST_IT);
`endif

    // Remainder stays below |B| <= 2^(WIDTH-1), so the shifted value never loses its top bit.
    assign w_div_shift = {r_acc[2*WIDTH-2:0], 1'b0};
    assign w_trial     = {1'b0, w_div_shift[2*WIDTH-1:WIDTH]} - {1'b0, r_opb};
    assign w_div_next  = w_trial[WIDTH] ? w_div_shift
                                        : {w_trial[WIDTH-1:0], w_div_shift[WIDTH-1:1], 1'b1};

    // Signed product fits in WIDTH bits only when its top WIDTH+1 bits all match.
    assign w_prod      = r_neg ? -r_acc : r_acc;
    assign w_mul_ovf   = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
    assign w_quo       = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    // A positive quotient with its sign bit set can only be MIN / -1.
    assign w_div_exc   = r_div0 | (~r_neg & r_acc[WIDTH-1]);

    always_ff @(posedge clock or negedge resetn) begin
        // NOTE: every register, datapath included, is cleared so a reset mid-operation leaves nothing stale.
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_opb    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_start) begin
            // NOTE: non-blocking assignments so every branch reads pre-edge register values.
            r_state  <= w_start_mul ? S_MUL_IT : (w_b_zero ? S_FIX : S_DIV_IT);
            r_cnt    <= '0;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_is_div <= ~w_start_mul;
            r_div0   <= ~w_start_mul & w_b_zero;
            r_acc    <= w_start_mul ? '0 : {{WIDTH{1'b0}}, w_a_mag};
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_opb    <= w_b_mag;
            r_rdy    <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_rdy <= 1'b0;
                end
                S_MUL_IT: begin
                    r_acc   <= w_mul_next;
                    r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
                    r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_mul_last) begin
                        r_state <= S_FIX;
                    end
                end
                S_DIV_IT: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_IT) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!r_is_div) begin
                        r_result <= w_prod[WIDTH-1:0];
                        r_exc    <= w_mul_ovf;
                    end else if (r_div0) begin
                        r_result <= '0;
                        r_exc    <= 1'b1;
                    end else begin
                        r_result <= w_quo;
                        r_exc    <= w_div_exc;
                    end
                    r_rdy   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_rdy   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_rdy   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;
    assign bus.data_resultRDY = r_rdy;
    assign bus.busy           = r_busy;
endmodule

// File: tb/tb_multdiv_seq.sv
// Directed bench for multdiv_seq: results, exceptions, latency, busy window, abort and reset.
// Honours MULTDIV_EARLY_TERM_EN for expected multiply latency.
module tb_multdiv_seq;
    logic clock = 1'b0;
    logic resetn;
    int   errors = 0;
    int   checks = 0;

`ifdef MULTDIV_EARLY_TERM_EN
    localparam bit          EARLY   = 1'b1;
    localparam logic [31:0] ABORT_B = 32'h0000_FFFF;
`else
    localparam bit          EARLY   = 1'b0;
    localparam logic [31:0] ABORT_B = 32'd3;
`endif

    multdiv_seq_if bus ();

    multdiv_seq dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int mul_lat(input int early_lat);
        return EARLY ? early_lat : 34;
    endfunction

    // Drive a start strobe so the rising edge ending cycle T samples it.
    task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_MULT     = mul;
        bus.ctrl_DIV      = div;
        @(posedge clock);
        #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = 32'hDEAD_BEEF;
        bus.data_operandB = 32'hDEAD_BEEF;
    endtask

    // Observe cycles T+1 .. T+lat+4 at the falling edge.
    task automatic watch(input int lat, input logic [31:0] exp_res, input logic exp_exc, input string tag);
        int          first   = -1;
        int          pulses  = 0;
        bit          busy_ok = 1'b1;
        logic [31:0] res     = 'x;
        logic        exc     = 1'bx;
        for (int c = 1; c <= lat + 4; c++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    res   = bus.data_result;
                    exc   = bus.data_exception;
                end
            end
            if (bus.busy !== (c < lat)) busy_ok = 1'b0;
        end
        check({tag, "_rdy_cycle"}, 32'(first), 32'(lat));
        check({tag, "_rdy_pulses"}, 32'(pulses), 32'd1);
        check({tag, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
        check({tag, "_result"}, res, exp_res);
        check({tag, "_exception"}, {31'd0, exc}, {31'd0, exp_exc});
        check({tag, "_result_held"}, bus.data_result, exp_res);
    endtask

    initial begin
        int pulses;
        int busy_seen;

        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        check("reset_result", bus.data_result, 32'd0);
        check("reset_exception", {31'd0, bus.data_exception}, 32'd0);
        check("reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        start_op(1'b1, 1'b0, 32'd7, -32'sd6);
        watch(mul_lat(5), 32'hFFFF_FFD6, 1'b0, "mul_7x-6");

        start_op(1'b1, 1'b0, 32'h4000_0000, 32'd4);
        watch(mul_lat(5), 32'h0000_0000, 1'b1, "mul_ovf");

        start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch(mul_lat(3), 32'd1, 1'b0, "mul_-1x-1");

        start_op(1'b1, 1'b0, 32'd3, 32'd3);
        watch(mul_lat(4), 32'd9, 1'b0, "mul_3x3");

        start_op(1'b1, 1'b1, 32'd7, -32'sd6);
        watch(mul_lat(5), 32'hFFFF_FFD6, 1'b0, "both_start");

        start_op(1'b0, 1'b1, -32'sd7, 32'd2);
        watch(34, 32'hFFFF_FFFD, 1'b0, "div_-7/2");

        start_op(1'b0, 1'b1, 32'd7, -32'sd2);
        watch(34, 32'hFFFF_FFFD, 1'b0, "div_7/-2");

        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        watch(34, 32'h8000_0000, 1'b1, "div_min/-1");

        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        watch(2, 32'd0, 1'b1, "div_by_zero");

        // Abort: a divide start at T+10 replaces the multiply in flight.
        start_op(1'b1, 1'b0, 32'd3, ABORT_B);
        pulses = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) pulses++;
        end
        check("abort_mul_no_rdy", 32'(pulses), 32'd0);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        watch(34, 32'd14, 1'b0, "abort_div");

        // Reset at T+15 of a multiply abandons it.
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFF);
        repeat (14) @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("midop_reset_result", bus.data_result, 32'd0);
        check("midop_reset_exception", {31'd0, bus.data_exception}, 32'd0);
        check("midop_reset_rdy", {31'd0, bus.data_resultRDY}, 32'd0);
        check("midop_reset_busy", {31'd0, bus.busy}, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        pulses    = 0;
        busy_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clock);
            if (bus.data_resultRDY === 1'b1) pulses++;
            if (bus.busy !== 1'b0) busy_seen++;
        end
        check("post_reset_no_rdy", 32'(pulses), 32'd0);
        check("post_reset_idle", 32'(busy_seen), 32'd0);
        start_op(1'b1, 1'b0, 32'd2, 32'd3);
        watch(mul_lat(4), 32'd6, 1'b0, "mul_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
